// File: rtl/cic_rate_ctrl_if.sv
// Rate-change request channel (AXI-Stream style) from the host/config bus
// into the CIC rate sequencing controller.
interface cic_rate_ctrl_if #(
  parameter int unsigned RATE_DW = 32
);
  logic [RATE_DW-1:0] s_axis_cfg_tdata;
  logic               s_axis_cfg_tvalid;
  logic               s_axis_cfg_tready;

  modport master (
    output s_axis_cfg_tdata,
    output s_axis_cfg_tvalid,
    input  s_axis_cfg_tready
  );

  modport slave (
    input  s_axis_cfg_tdata,
    input  s_axis_cfg_tvalid,
    output s_axis_cfg_tready
  );
endinterface

// File: rtl/cic_rate_ctrl.sv
// Sequencing controller for the variable-rate CIC decimator: range-checks
// rate requests, waits for an output boundary, flushes the filter, loads the
// new rate and masks outputs until the comb pipeline has refilled.
module cic_rate_ctrl #(
  parameter int unsigned RATE_DW      = 32,
  parameter int unsigned CIC_R        = 10,
  parameter int unsigned CIC_N        = 7,
  parameter int unsigned CIC_M        = 1,
  parameter int unsigned FLUSH_CYCLES = 8,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  cic_rate_ctrl_if.slave     cfg,
  input  logic               filt_out_tvalid,
  output logic               filt_reset_n,
  output logic [RATE_DW-1:0] filt_rate_tdata,
  output logic               filt_rate_tvalid,
  output logic               out_gate,
  output logic               busy,
  output logic               cfg_error,
  output logic [RATE_DW-1:0] current_rate
);

  localparam int unsigned SETTLE_OUTS = CIC_N * CIC_M;
  localparam int unsigned WAIT_W      = $clog2(WAIT_TIMEOUT) + 1;
  localparam int unsigned FLUSH_W     = $clog2(FLUSH_CYCLES) + 1;
  localparam int unsigned SETTLE_W    = $clog2(SETTLE_OUTS) + 1;

  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(WAIT_TIMEOUT - 1);
  localparam logic [FLUSH_W-1:0]  FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_OUTS - 1);
  localparam logic [RATE_DW-1:0]  RATE_MAX    = RATE_DW'(CIC_R);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BOUND,
    FLUSH,
    APPLY,
    SETTLE
  } state_t;

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [RATE_DW-1:0]  pending_rate;
  logic                handshake;
  logic                err_next;
  logic                load_pending;

  assign handshake = cfg.s_axis_cfg_tvalid & cfg.s_axis_cfg_tready;

  // Next-state decode and request classification.
  always_comb begin
    state_next   = state;
    err_next     = 1'b0;
    load_pending = 1'b0;
    unique case (state)
      IDLE: begin
        if (handshake) begin
          if ((cfg.s_axis_cfg_tdata == '0) || (cfg.s_axis_cfg_tdata > RATE_MAX)) begin
            err_next = 1'b1;
          end else if (cfg.s_axis_cfg_tdata != current_rate) begin
            load_pending = 1'b1;
            state_next   = WAIT_BOUND;
          end
        end
      end
      WAIT_BOUND: begin
        if (filt_out_tvalid || (wait_cnt == WAIT_LAST)) state_next = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_next = APPLY;
      end
      APPLY: begin
        state_next = SETTLE;
      end
      SETTLE: begin
        if (filt_out_tvalid && (settle_cnt == SETTLE_LAST)) state_next = IDLE;
      end
      default: begin
        state_next = SETTLE;
      end
    endcase
  end

  // State register; reset lands in SETTLE so post-reset transients are masked.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= SETTLE;
    else          state <= state_next;
  end

  // Per-state counters, cleared on every state change.
  always_ff @(posedge clk) begin
    if (!reset_n || (state_next != state)) begin
      wait_cnt   <= '0;
      flush_cnt  <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        WAIT_BOUND: wait_cnt  <= wait_cnt + WAIT_W'(1);
        FLUSH:      flush_cnt <= flush_cnt + FLUSH_W'(1);
        SETTLE:     if (filt_out_tvalid) settle_cnt <= settle_cnt + SETTLE_W'(1);
        default: ;
      endcase
    end
  end

  // Pending rate capture on an accepted, actionable request.
  always_ff @(posedge clk) begin
    if (!reset_n)          pending_rate <= '0;
    else if (load_pending) pending_rate <= cfg.s_axis_cfg_tdata;
  end

  // Outputs are registered from the next state so each one lines up with
  // the state it describes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_reset_n          <= 1'b0;
      filt_rate_tvalid      <= 1'b0;
      filt_rate_tdata       <= RATE_MAX;
      current_rate          <= RATE_MAX;
      out_gate              <= 1'b0;
      busy                  <= 1'b1;
      cfg_error             <= 1'b0;
      cfg.s_axis_cfg_tready <= 1'b0;
    end else begin
      filt_reset_n          <= (state_next != FLUSH);
      filt_rate_tvalid      <= (state_next == APPLY);
      out_gate              <= (state_next == IDLE) || (state_next == WAIT_BOUND);
      busy                  <= (state_next != IDLE);
      cfg_error             <= err_next;
      cfg.s_axis_cfg_tready <= (state_next == IDLE);
      if (state_next == APPLY) begin
        filt_rate_tdata <= pending_rate;
        current_rate    <= pending_rate;
      end
    end
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl with default parameters (R=10, N=7, M=1,
// 8 flush cycles, 1024-cycle boundary timeout).
module tb_cic_rate_ctrl;

  logic        clk;
  logic        reset_n;
  logic        filt_out_tvalid;
  logic        filt_reset_n;
  logic [31:0] filt_rate_tdata;
  logic        filt_rate_tvalid;
  logic        out_gate;
  logic        busy;
  logic        cfg_error;
  logic [31:0] current_rate;

  int unsigned n_checks;
  int unsigned n_errors;

  cic_rate_ctrl_if #(.RATE_DW(32)) cfg_if ();

  cic_rate_ctrl #(
    .RATE_DW     (32),
    .CIC_R       (10),
    .CIC_N       (7),
    .CIC_M       (1),
    .FLUSH_CYCLES(8),
    .WAIT_TIMEOUT(1024)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg             (cfg_if.slave),
    .filt_out_tvalid (filt_out_tvalid),
    .filt_reset_n    (filt_reset_n),
    .filt_rate_tdata (filt_rate_tdata),
    .filt_rate_tvalid(filt_rate_tvalid),
    .out_gate        (out_gate),
    .busy            (busy),
    .cfg_error       (cfg_error),
    .current_rate    (current_rate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rate(input logic [31:0] r);
    cfg_if.s_axis_cfg_tdata  = r;
    cfg_if.s_axis_cfg_tvalid = 1'b1;
    step();
    cfg_if.s_axis_cfg_tvalid = 1'b0;
  endtask

  // Feed 7 output pulses; gate must stay closed through the 7th and open after.
  task automatic settle_outputs(input string tag, input logic [31:0] rate);
    for (int i = 0; i < 7; i++) begin
      check_eq({tag, "_gate_closed"}, 32'(out_gate), 32'd0);
      filt_out_tvalid = 1'b1;
      step();
      filt_out_tvalid = 1'b0;
      if (i < 6) begin
        check_eq({tag, "_gate_mid"}, 32'(out_gate), 32'd0);
        step();
      end
    end
    check_eq({tag, "_gate_open"}, 32'(out_gate), 32'd1);
    check_eq({tag, "_tready"}, 32'(cfg_if.s_axis_cfg_tready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rate"}, current_rate, rate);
  endtask

  // Count filt_reset_n low cycles (bounded), then check the APPLY cycle.
  task automatic flush_and_apply(input string tag, input logic [31:0] rate);
    int unsigned low;
    low = 0;
    while (filt_reset_n == 1'b0 && low < 50) begin
      check_eq({tag, "_flush_gate"}, 32'(out_gate), 32'd0);
      filt_out_tvalid = (low == 3);
      low++;
      step();
    end
    filt_out_tvalid = 1'b0;
    check_eq({tag, "_flush_len"}, low, 32'd8);
    check_eq({tag, "_apply_rst"}, 32'(filt_reset_n), 32'd1);
    check_eq({tag, "_apply_strobe"}, 32'(filt_rate_tvalid), 32'd1);
    check_eq({tag, "_apply_tdata"}, filt_rate_tdata, rate);
    check_eq({tag, "_apply_cur"}, current_rate, rate);
    check_eq({tag, "_apply_gate"}, 32'(out_gate), 32'd0);
    step();
    check_eq({tag, "_strobe_done"}, 32'(filt_rate_tvalid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_filt_rst"}, 32'(filt_reset_n), 32'd0);
    check_eq({tag, "_gate"}, 32'(out_gate), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_tready"}, 32'(cfg_if.s_axis_cfg_tready), 32'd0);
    check_eq({tag, "_strobe"}, 32'(filt_rate_tvalid), 32'd0);
    check_eq({tag, "_tdata"}, filt_rate_tdata, 32'd10);
    check_eq({tag, "_cur"}, current_rate, 32'd10);
    check_eq({tag, "_err"}, 32'(cfg_error), 32'd0);
  endtask

  initial begin
    int unsigned wcnt;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    filt_out_tvalid          = 1'b0;
    cfg_if.s_axis_cfg_tdata  = '0;
    cfg_if.s_axis_cfg_tvalid = 1'b0;
    repeat (3) step();
    check_reset_values("rst");

    // Post-reset settle.
    reset_n = 1'b1;
    step();
    check_eq("rst_release_filt_rst", 32'(filt_reset_n), 32'd1);
    check_eq("rst_release_busy", 32'(busy), 32'd1);
    settle_outputs("init", 32'd10);

    // Rate 5 with a boundary 20 cycles later.
    send_rate(32'd5);
    check_eq("wb_busy", 32'(busy), 32'd1);
    check_eq("wb_tready", 32'(cfg_if.s_axis_cfg_tready), 32'd0);
    check_eq("wb_gate", 32'(out_gate), 32'd1);
    check_eq("wb_filt_rst", 32'(filt_reset_n), 32'd1);
    repeat (19) step();
    check_eq("wb_still_waiting", 32'(filt_reset_n), 32'd1);
    filt_out_tvalid = 1'b1;
    step();
    filt_out_tvalid = 1'b0;
    flush_and_apply("r5", 32'd5);
    settle_outputs("r5", 32'd5);

    // Out-of-range requests.
    send_rate(32'd0);
    check_eq("r0_err", 32'(cfg_error), 32'd1);
    check_eq("r0_tready", 32'(cfg_if.s_axis_cfg_tready), 32'd1);
    check_eq("r0_busy", 32'(busy), 32'd0);
    step();
    check_eq("r0_err_pulse", 32'(cfg_error), 32'd0);
    send_rate(32'd11);
    check_eq("r11_err", 32'(cfg_error), 32'd1);
    check_eq("r11_cur", current_rate, 32'd5);
    check_eq("r11_filt_rst", 32'(filt_reset_n), 32'd1);
    check_eq("r11_strobe", 32'(filt_rate_tvalid), 32'd0);
    step();
    check_eq("r11_err_pulse", 32'(cfg_error), 32'd0);
    check_eq("r11_tready", 32'(cfg_if.s_axis_cfg_tready), 32'd1);

    // Same-rate request is a no-op.
    send_rate(32'd5);
    check_eq("same_busy", 32'(busy), 32'd0);
    check_eq("same_err", 32'(cfg_error), 32'd0);
    repeat (3) step();
    check_eq("same_busy_later", 32'(busy), 32'd0);
    check_eq("same_filt_rst", 32'(filt_reset_n), 32'd1);

    // Rate 10 accepted (max boundary) with no output: timeout forces flush.
    send_rate(32'd10);
    wcnt = 0;
    while (filt_reset_n == 1'b1 && wcnt < 2000) begin
      wcnt++;
      step();
    end
    check_eq("timeout_len", wcnt, 32'd1024);
    flush_and_apply("r10", 32'd10);
    settle_outputs("r10", 32'd10);

    // Rate 3, timeout path again from a non-default current rate.
    send_rate(32'd3);
    wcnt = 0;
    while (filt_reset_n == 1'b1 && wcnt < 2000) begin
      wcnt++;
      step();
    end
    check_eq("timeout3_len", wcnt, 32'd1024);
    flush_and_apply("r3", 32'd3);
    settle_outputs("r3", 32'd3);

    // Rate 4, reset asserted mid-flush: pending rate must be discarded.
    send_rate(32'd4);
    filt_out_tvalid = 1'b1;
    step();
    filt_out_tvalid = 1'b0;
    repeat (3) step();
    check_eq("mid_flush_rst", 32'(filt_reset_n), 32'd0);
    reset_n = 1'b0;
    step();
    check_reset_values("abort");
    reset_n = 1'b1;
    step();
    settle_outputs("abort", 32'd10);
    check_eq("abort_tdata", filt_rate_tdata, 32'd10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
